// File: rtl/seg7_decoder.sv
// Reads back a multiplexed 4-digit 7-segment display bus and turns it into a 16-bit hex frame.
// Each digit is debounced, decoded, collected into a shadow frame, then published with a strobe.
module seg7_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          AN_ACTIVE_LOW  = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segment,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic [3:0]  captured
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StCount, StHeld} state_t;

    logic [7:0]  w_seg_n;
    logic [3:0]  w_an_n;
    logic        w_onehot;
    logic        w_same;
    logic [1:0]  w_idx;
    logic [3:0]  w_nib;
    logic        w_nib_err;
    logic [7:0]  w_cnt_nxt;
    state_t      w_state_nxt;
    logic        w_capture;
    logic [3:0]  w_mask_nxt;
    logic        w_pub_nxt;

    logic [11:0] r_sample;
    logic [7:0]  r_cnt;
    state_t      r_state;
    logic [15:0] r_shadow_val;
    logic [3:0]  r_shadow_dp;
    logic [3:0]  r_shadow_err;
    logic [3:0]  r_mask;
    logic        r_pub_pend;
    logic [15:0] r_value;
    logic [3:0]  r_dp;
    logic [3:0]  r_err;
    logic        r_frame_valid;

    assign w_seg_n  = segment ^ {8{SEG_ACTIVE_LOW}};
    assign w_an_n   = an ^ {4{AN_ACTIVE_LOW}};
    assign w_onehot = (w_an_n != 4'b0000) && ((w_an_n & (w_an_n - 4'd1)) == 4'b0000);
    assign w_same   = ({w_an_n, w_seg_n} == r_sample);

    always_comb begin
        w_idx = 2'd0;
        case (w_an_n)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Segments a..g with a as MSB; dp is decoded separately.
    always_comb begin
        w_nib     = 4'h0;
        w_nib_err = 1'b0;
        case (w_seg_n[7:1])
            7'h7E: w_nib = 4'h0;
            7'h30: w_nib = 4'h1;
            7'h6D: w_nib = 4'h2;
            7'h79: w_nib = 4'h3;
            7'h33: w_nib = 4'h4;
            7'h5B: w_nib = 4'h5;
            7'h5F: w_nib = 4'h6;
            7'h70: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h7B: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h1F: w_nib = 4'hB;
            7'h4E: w_nib = 4'hC;
            7'h3D: w_nib = 4'hD;
            7'h4F: w_nib = 4'hE;
            7'h47: w_nib = 4'hF;
            default: begin
                w_nib     = 4'h0;
                w_nib_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = StIdle;
        if (!w_onehot) begin
            w_cnt_nxt = 8'd0;
        end else if (w_same) begin
            w_cnt_nxt = (r_cnt >= STABLE) ? STABLE : r_cnt + 8'd1;
        end else begin
            w_cnt_nxt = 8'd1;
        end

        if (w_cnt_nxt == 8'd0) begin
            w_state_nxt = StIdle;
        end else if (w_cnt_nxt == STABLE) begin
            w_state_nxt = StHeld;
        end else begin
            w_state_nxt = StCount;
        end

        // A fresh pattern reaching the threshold (possible at once when STABLE_CYCLES is 1)
        // also counts as entering HELD.
        w_capture = (w_state_nxt == StHeld) && ((r_state != StHeld) || !w_same);

        w_mask_nxt = r_pub_pend ? 4'b0000 : r_mask;
        if (w_capture) begin
            w_mask_nxt = w_mask_nxt | w_an_n;
        end
        w_pub_nxt = w_capture && (w_mask_nxt == 4'b1111);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 12'h000;
            r_cnt    <= 8'd0;
            r_state  <= StIdle;
        end else begin
            r_sample <= {w_an_n, w_seg_n};
            r_cnt    <= w_cnt_nxt;
            r_state  <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'b0000;
            r_shadow_err <= 4'b0000;
            r_mask       <= 4'b0000;
            r_pub_pend   <= 1'b0;
        end else begin
            r_mask     <= w_mask_nxt;
            r_pub_pend <= w_pub_nxt;
            if (w_capture) begin
                r_shadow_val[{w_idx, 2'b00} +: 4] <= w_nib;
                r_shadow_dp[w_idx]                <= w_seg_n[0];
                r_shadow_err[w_idx]               <= w_nib_err;
            end
        end
    end

    // Shadow slot written on a publish edge lands after the copy, so it joins the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value       <= 16'h0000;
            r_dp          <= 4'b0000;
            r_err         <= 4'b0000;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= r_pub_pend;
            if (r_pub_pend) begin
                r_value <= r_shadow_val;
                r_dp    <= r_shadow_dp;
                r_err   <= r_shadow_err;
            end
        end
    end

    assign value       = r_value;
    assign dp          = r_dp;
    assign err         = r_err;
    assign frame_valid = r_frame_valid;
    assign captured    = r_mask;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: default, inverted-polarity and single-cycle-stable instances
// all watch the same display bus.
module tb_seg7_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  segment;
    logic [3:0]  an;
    logic [7:0]  seg_inv;
    logic [3:0]  an_inv;

    logic [15:0] value, value_i, value_s;
    logic [3:0]  dp, dp_i, dp_s;
    logic [3:0]  err, err_i, err_s;
    logic        fv, fv_i, fv_s;
    logic [3:0]  cap, cap_i, cap_s;

    int checks = 0;
    int errors = 0;

    assign seg_inv = ~segment;
    assign an_inv  = ~an;

    seg7_decoder dut (
        .clk(clk), .rst(rst), .segment(segment), .an(an),
        .value(value), .dp(dp), .err(err), .frame_valid(fv), .captured(cap)
    );

    seg7_decoder #(.STABLE_CYCLES(4), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .segment(seg_inv), .an(an_inv),
        .value(value_i), .dp(dp_i), .err(err_i), .frame_valid(fv_i), .captured(cap_i)
    );

    seg7_decoder #(.STABLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .segment(segment), .an(an),
        .value(value_s), .dp(dp_s), .err(err_s), .frame_valid(fv_s), .captured(cap_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an      = a;
        segment = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic [15:0] ev, input logic [3:0] edp, input logic [3:0] eerr);
        hold(4'b0001, s0, 4);
        hold(4'b0010, s1, 4);
        hold(4'b0100, s2, 4);
        hold(4'b1000, s3, 4);
        chk({tag, " captured full"}, 16'(cap), 16'h000F);
        chk({tag, " no early strobe"}, 16'(fv), 16'h0000);
        hold(4'b0000, 8'h00, 1);
        chk({tag, " strobe"}, 16'(fv), 16'h0001);
        chk({tag, " value"}, value, ev);
        chk({tag, " dp"}, 16'(dp), 16'(edp));
        chk({tag, " err"}, 16'(err), 16'(eerr));
        chk({tag, " captured cleared"}, 16'(cap), 16'h0000);
        chk({tag, " inv value"}, value_i, ev);
        hold(4'b0000, 8'h00, 1);
        chk({tag, " strobe one cycle"}, 16'(fv), 16'h0000);
        chk({tag, " value holds"}, value, ev);
    endtask

    initial begin
        rst     = 1'b1;
        an      = 4'b0000;
        segment = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset value", value, 16'h0000);
        chk("reset captured", 16'(cap), 16'h0000);
        chk("reset strobe", 16'(fv), 16'h0000);
        rst = 1'b0;
        hold(4'b0000, 8'h00, 1);

        // Frame 0x2150: digit0=0, digit1=5, digit2=1, digit3=2
        hold(4'b0001, 8'hFC, 1);
        chk("t1 no capture at edge1", 16'(cap), 16'h0000);
        chk("t1 s1 capture at edge1", 16'(cap_s), 16'h0001);
        hold(4'b0001, 8'hFC, 3);
        chk("t1 capture at edge4", 16'(cap), 16'h0001);
        hold(4'b0010, 8'hB6, 4);
        hold(4'b0100, 8'h60, 4);
        chk("t1 captured 0111", 16'(cap), 16'h0007);
        chk("t1 inv captured 0111", 16'(cap_i), 16'h0007);
        hold(4'b1000, 8'hDA, 1);
        chk("t1 s1 captured full", 16'(cap_s), 16'h000F);
        chk("t1 s1 no early strobe", 16'(fv_s), 16'h0000);
        hold(4'b1000, 8'hDA, 1);
        chk("t1 s1 strobe", 16'(fv_s), 16'h0001);
        chk("t1 s1 value", value_s, 16'h2150);
        hold(4'b1000, 8'hDA, 2);
        chk("t1 captured full", 16'(cap), 16'h000F);
        chk("t1 no early strobe", 16'(fv), 16'h0000);
        hold(4'b0000, 8'h00, 1);
        chk("t1 strobe", 16'(fv), 16'h0001);
        chk("t1 value", value, 16'h2150);
        chk("t1 err", 16'(err), 16'h0000);
        chk("t1 captured cleared", 16'(cap), 16'h0000);
        chk("t1 inv strobe", 16'(fv_i), 16'h0001);
        chk("t1 inv value", value_i, 16'h2150);
        hold(4'b0000, 8'h00, 1);
        chk("t1 strobe one cycle", 16'(fv), 16'h0000);

        run_frame("t2", 8'hFD, 8'hEE, 8'hEE, 8'hEE, 16'hAAA0, 4'b0001, 4'b0000);
        chk("t2 s1 value", value_s, 16'hAAA0);
        chk("t2 s1 dp", 16'(dp_s), 16'h0001);

        run_frame("t3", 8'hFC, 8'h60, 8'h02, 8'hDA, 16'h2010, 4'b0000, 4'b0100);
        chk("t3 inv err", 16'(err_i), 16'h0004);

        // Glitches and non-one-hot selects
        hold(4'b0001, 8'hFC, 4);
        chk("t4 digit0 captured", 16'(cap), 16'h0001);
        hold(4'b0010, 8'h60, 3);
        chk("t4 short hold no capture", 16'(cap), 16'h0001);
        hold(4'b0011, 8'h60, 10);
        chk("t4 two selects mask kept", 16'(cap), 16'h0001);
        hold(4'b0010, 8'h60, 3);
        hold(4'b0010, 8'hB6, 3);
        chk("t4 glitch restarts count", 16'(cap), 16'h0001);
        hold(4'b0010, 8'hB6, 1);
        chk("t4 capture after restart", 16'(cap), 16'h0003);

        // Reset mid-frame
        hold(4'b0100, 8'h60, 4);
        chk("t5 captured before reset", 16'(cap), 16'h0007);
        #3;
        rst = 1'b1;
        #1;
        chk("t5 reset value", value, 16'h0000);
        chk("t5 reset err", 16'(err), 16'h0000);
        chk("t5 reset dp", 16'(dp), 16'h0000);
        chk("t5 reset captured", 16'(cap), 16'h0000);
        chk("t5 reset strobe", 16'(fv), 16'h0000);
        chk("t5 s1 reset value", value_s, 16'h0000);
        an      = 4'b0000;
        segment = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(4'b0000, 8'h00, 1);
        run_frame("t5", 8'hFC, 8'hB6, 8'h60, 8'hDA, 16'h2150, 4'b0000, 4'b0000);
        chk("t5 s1 value", value_s, 16'h2150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
# seg7_decoder

Reverse-direction companion to the team's hex-to-7-segment encoder: watches a multiplexed 4-digit display bus (one segment byte plus one digit-select line per digit) and recovers the displayed 16-bit hex value. It debounces each digit's pattern, decodes it back to a nibble, collects all four digits into a frame, and publishes the frame with a one-cycle strobe. It sits beside the display driver as a self-check and readback path for board-level verification.

## Interface
- STABLE_CYCLES, 4, consecutive identical cycles required before a digit is captured; legal range 1..255.
- AN_ACTIVE_LOW, 0, 1 = digit selects are active-low at the port.
- SEG_ACTIVE_LOW, 0, 1 = segment bits are active-low at the port.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- segment  in  8  segment bus, bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; synchronous to clk.
- an  in  4  digit selects, an[i] selects digit i (digit 0 = least significant nibble); synchronous to clk.
- value  out  16  last published frame, digit i in value[4i+3:4i].
- dp  out  4  last published decimal-point bits, dp[i] for digit i.
- err  out  4  last published per-digit invalid-pattern flags.
- frame_valid  out  1  one-cycle pulse when value/dp/err update.
- captured  out  4  digits captured so far in the frame being assembled.

## Operation
- Polarity normalisation is combinational: seg_n = segment ^ {8{SEG_ACTIVE_LOW}}, an_n = an ^ {4{AN_ACTIVE_LOW}}; everything below uses seg_n/an_n.
- Decode on seg_n[7:1] (dp ignored): 0x7E→0, 0x30→1, 0x6D→2, 0x79→3, 0x33→4, 0x5B→5, 0x5F→6, 0x70→7, 0x7F→8, 0x7B→9, 0x77→A, 0x1F→b, 0x4E→C, 0x3D→d, 0x4F→E, 0x47→F (byte values are segment[7:0]>>1, i.e. a..g with a as MSB). Any other pattern, including all-off, decodes to nibble 0 with err=1.
- Sample register s_sample = {an_n, seg_n}, reset to all-zero, loaded every cycle.
- Stability counter cnt (8 bit, reset 0), per edge: an_n not one-hot → cnt<=0; one-hot and {an_n,seg_n}==s_sample → cnt<=min(cnt+1, STABLE_CYCLES); one-hot and different → cnt<=1.
- State machine: IDLE (cnt=0, an_n not one-hot), COUNT (0<cnt<STABLE_CYCLES), HELD (cnt==STABLE_CYCLES). Capture fires on the edge where cnt moves to STABLE_CYCLES from a lower value; HELD never recaptures until the input changes or leaves one-hot.
- Capture into shadow slot i = index of the set an_n bit: nibble, dp bit seg_n[0], err bit; set mask bit i. Recapture of an already-set slot overwrites it (latest wins).
- Publish: the edge after a capture leaves mask==4'b1111, copy shadow to value/dp/err, pulse frame_valid, clear mask. If a capture fires on that same publish edge, mask <= only that capture's bit and its shadow slot is written after the copy (it belongs to the next frame).
- captured = mask.

## Timing
- Reset (async assert, any time): value=0, dp=0, err=0, frame_valid=0, captured=0, cnt=0, s_sample=0, shadow=0; an in-progress frame is discarded.
- Capture latency: input constant from before edge 1 → cnt=1 at edge 1, capture at edge STABLE_CYCLES (edge 1 when STABLE_CYCLES=1).
- Publish latency: one edge after the completing capture; frame_valid high exactly one cycle; outputs hold until next publish.
- Glitch shorter than STABLE_CYCLES cycles: no capture; restart counting on the new value.
- an_n with 0 or ≥2 bits set: no capture, mask retained.
- No backpressure: a consumer that misses frame_valid sees only the latest value.

## Test plan
- Defaults, drive an=0001 seg=0xFC 4 cycles, then 0010/0xB6, 0100/0x60, 1000/0xDA, each 4 cycles → capture edges 4,8,12,16; frame_valid pulse at edge 17 with value=0x2150, err=0, captured=0 after.
- Digit 0 seg=0xFD (0 with dp), others 0xEE → value=0xAAA0, dp=4'b0001.
- Digit 2 seg=0x02 (g only), others valid → err=4'b0100, nibble 2 of value=0.
- Digit 1 pattern held 3 cycles then changed (STABLE_CYCLES=4) → no capture, captured bit 1 stays 0; an=0011 for 10 cycles → no capture.
- AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1, inverted stimulus of test 1 → identical value=0x2150; STABLE_CYCLES=1 → capture on first edge of each digit.
- Assert rst mid-frame with captured=4'b0111 → all outputs 0 immediately; next full frame publishes normally.
